fpnew_req_scheduler: RTL



---
 rtl/fpnew_pkg.sv | 58 +++++
 rtl/fpnew_req_scheduler_arb.sv | 70 +++++++
 rtl/fpnew_req_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPU types used by the request scheduler: rounding modes, operation
// codes, formats, the IEEE status flags and the packed issue request.
// sched_idx_width() gives the number of tag bits that carry a requester index.
package fpnew_pkg;

  // Operand width of the shared fpnew_top instance (its Features.Width).
  localparam int unsigned SCHED_WIDTH  = 64;
  localparam int unsigned NUM_OPERANDS = 3;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8, INT16, INT32, INT64
  } int_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Everything a requester hands to the FPU for one operation.
  typedef struct packed {
    logic [NUM_OPERANDS-1:0][SCHED_WIDTH-1:0] operands;
    roundmode_e                               rnd_mode;
    operation_e                               op;
    logic                                     op_mod;
    fp_format_e                               src_fmt;
    fp_format_e                               dst_fmt;
    int_format_e                              int_fmt;
    logic                                     vectorial_op;
  } sched_req_t;

  // Index bits needed to name one of n requesters (at least one bit).
  function automatic int unsigned sched_idx_width(int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/fpnew_req_scheduler_arb.sv
// Round-robin arbiter with grant lock and valid/ready semantics, behaving like
// rr_arb_tree with LockIn=1 and AxiVldRdy=1. Once a grant is shown and not
// yet accepted it stays on the same input until gnt_i. The priority pointer
// moves to winner+1 on acceptance; flush drops the lock but keeps the pointer.
module fpnew_req_scheduler_arb #(
  parameter int unsigned NumIn    = 2,
  parameter int unsigned IdxWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [NumIn-1:0]    req_i,
  input  logic                gnt_i,
  output logic                valid_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic [IdxWidth-1:0] rr_ptr_q;
  logic                lock_q;
  logic [IdxWidth-1:0] lock_idx_q;

  logic                hi_found;
  logic [IdxWidth-1:0] hi_idx;
  logic                lo_found;
  logic [IdxWidth-1:0] lo_idx;
  logic                lock_hit;

  // Lowest request at/above the pointer, and lowest request overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = IdxWidth'(i);
        if (IdxWidth'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IdxWidth'(i);
        end
      end
    end
  end

  // A held grant wins as long as its requester still asks.
  assign lock_hit = lock_q && req_i[lock_idx_q];
  assign idx_o    = lock_hit ? lock_idx_q : (hi_found ? hi_idx : lo_idx);
  assign valid_o  = lo_found && !flush_i;

  // Pointer advance on acceptance, lock capture while the FPU stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      lock_q <= 1'b0;
    end else if (valid_o) begin
      if (gnt_i) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + 1'b1;
      end else begin
        lock_q     <= 1'b1;
        lock_idx_q <= idx_o;
      end
    end
  end

endmodule

// File: rtl/fpnew_req_scheduler.sv
// Shares one fpnew_top between NumReq requesters. Issues are arbitrated
// round-robin among requesters that still hold a credit; the requester index
// rides in the top bits of the FPU tag and steers the result back.
// Optional feature macro: FPNEW_SCHED_PERF_EN builds the per-requester
// saturating issue counters behind perf_issued_o (tied to zero otherwise).
module fpnew_req_scheduler
  import fpnew_pkg::*;
#(
  parameter int unsigned  NumReq         = 2,
  parameter int unsigned  MaxOutstanding = 4,
  parameter int unsigned  Width          = 64,
  parameter int unsigned  UserTagWidth   = 4,
  localparam int unsigned IdxWidth       = sched_idx_width(NumReq),
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
  localparam int unsigned TagWidth       = IdxWidth + UserTagWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  sched_req_t [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0][UserTagWidth-1:0]  req_tag_i,
  output logic                                 fpu_valid_o,
  input  logic                                 fpu_ready_i,
  output sched_req_t                           fpu_req_o,
  output logic [TagWidth-1:0]                  fpu_tag_o,
  output logic                                 fpu_flush_o,
  input  logic                                 fpu_out_valid_i,
  output logic                                 fpu_out_ready_o,
  input  logic [Width-1:0]                     fpu_result_i,
  input  status_t                              fpu_status_i,
  input  logic [TagWidth-1:0]                  fpu_tag_i,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [Width-1:0]                     rsp_result_o,
  output status_t                              rsp_status_o,
  output logic [UserTagWidth-1:0]              rsp_tag_o,
  output logic                                 busy_o,
  output logic [NumReq-1:0][31:0]              perf_issued_o
);

  logic [NumReq-1:0]   elig;
  logic [NumReq-1:0]   inc;
  logic [NumReq-1:0]   dec;
  logic [CntWidth-1:0] cnt_q [NumReq];

  logic                arb_valid;
  logic [IdxWidth-1:0] win_idx;
  logic [IdxWidth-1:0] rsp_idx;
  logic                idx_ok;
  logic                rsp_active;

  // ---------------------------------------------------------------- issue
  fpnew_req_scheduler_arb #(
    .NumIn    (NumReq),
    .IdxWidth (IdxWidth)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .req_i   (elig),
    .gnt_i   (fpu_ready_i),
    .valid_o (arb_valid),
    .idx_o   (win_idx)
  );

  // Valid is built from requests and credits only, never from fpu_ready_i,
  // because fpnew_top derives its ready from our valid.
  assign fpu_valid_o = rst_ni && arb_valid;
  assign fpu_req_o   = req_i[win_idx];
  assign fpu_tag_o   = {win_idx, req_tag_i[win_idx]};
  assign fpu_flush_o = flush_i;

  // ------------------------------------------------------------- response
  assign rsp_idx      = fpu_tag_i[TagWidth-1 -: IdxWidth];
  assign rsp_result_o = fpu_result_i;
  assign rsp_status_o = fpu_status_i;
  assign rsp_tag_o    = fpu_tag_i[UserTagWidth-1:0];

  // With a power-of-two requester count every index is legal.
  if (NumReq == (1 << IdxWidth)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = ({1'b0, rsp_idx} < (IdxWidth + 1)'(NumReq));
  end

  assign rsp_active = rst_ni && !flush_i && fpu_out_valid_i && idx_ok;

  // Results are drained while flushing and when the index is bogus.
  assign fpu_out_ready_o = rst_ni && (flush_i || !idx_ok || rsp_ready_i[rsp_idx]);

  // ------------------------------------------------------ per requester
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    assign elig[gi]        = req_valid_i[gi] && (cnt_q[gi] < CntWidth'(MaxOutstanding));
    assign req_ready_o[gi] = fpu_valid_o && fpu_ready_i && (win_idx == IdxWidth'(gi));
    assign rsp_valid_o[gi] = rsp_active && (rsp_idx == IdxWidth'(gi));
    assign inc[gi]         = req_ready_o[gi];
    assign dec[gi]         = rsp_valid_o[gi] && rsp_ready_i[gi];

    // Outstanding-operation credit: +1 per issue, -1 per delivered result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q[gi] <= '0;
      end else if (flush_i) begin
        cnt_q[gi] <= '0;
      end else if (inc[gi] && !dec[gi]) begin
        cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end else if (dec[gi] && !inc[gi]) begin
        cnt_q[gi] <= cnt_q[gi] - 1'b1;
      end
    end

    // A result for a requester with nothing in flight means a corrupted tag.
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      dec[gi] |-> (cnt_q[gi] != '0));

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (inc[gi] && !dec[gi]) |-> (cnt_q[gi] < CntWidth'(MaxOutstanding)));
  end

  a_rsp_idx_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fpu_out_valid_i |-> idx_ok);

  // Busy while any requester still owns an operation inside the FPU.
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      busy_o = busy_o | (cnt_q[i] != '0);
    end
  end

  // ---------------------------------------------------------- perf counters
`ifdef FPNEW_SCHED_PERF_EN
  logic [31:0] perf_q [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_perf
    // Saturating issue count; survives flush, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        perf_q[gi] <= '0;
      end else if (inc[gi] && (perf_q[gi] != '1)) begin
        perf_q[gi] <= perf_q[gi] + 32'd1;
      end
    end
    assign perf_issued_o[gi] = perf_q[gi];
  end
`else
  assign perf_issued_o = '0;
`endif

endmodule
